// File: rtl/time_of_day_counter.sv
// Time-of-day counter: hours/minutes/seconds advanced by a prescaled one-second strobe,
// with validated loads and one-cycle rollover strobes. Define TOD_BCD_OUT_EN to add BCD outputs.
module time_of_day_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       hold,
  input  logic       load_new_time,
  input  logic [4:0] new_hour,
  input  logic [5:0] new_min,
  output logic [4:0] cur_hour,
  output logic [5:0] cur_min,
  output logic [5:0] cur_sec,
  output logic       minute_tick,
  output logic       day_rollover,
  output logic       load_error
`ifdef TOD_BCD_OUT_EN
  ,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd
`endif
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [4:0]       hour_reg, hour_next;
  logic [5:0]       min_reg, min_next;
  logic [5:0]       sec_reg, sec_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic             minute_tick_reg, minute_tick_next;
  logic             day_rollover_reg, day_rollover_next;
  logic             load_error_reg, load_error_next;
  logic             step;

  always_comb begin
    hour_next         = hour_reg;
    min_next          = min_reg;
    sec_next          = sec_reg;
    div_cnt_next      = div_cnt_reg;
    minute_tick_next  = 1'b0;
    day_rollover_next = 1'b0;
    load_error_next   = 1'b0;
    step              = 1'b0;

    // A load of either kind swallows any tick in the same cycle.
    if (load_new_time) begin
      if (new_hour <= 5'd23 && new_min <= 6'd59) begin
        hour_next    = new_hour;
        min_next     = new_min;
        sec_next     = 6'd0;
        div_cnt_next = '0;
      end else begin
        load_error_next = 1'b1;
      end
    end else if (!hold && one_second) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_next = '0;
        step         = 1'b1;
      end else begin
        div_cnt_next = div_cnt_reg + 1'b1;
      end
    end

    // ">=" comparisons make a forced out-of-range field wrap to 0 on the next step.
    if (step) begin
      if (sec_reg >= 6'd59) begin
        sec_next         = 6'd0;
        minute_tick_next = 1'b1;
        if (min_reg >= 6'd59) begin
          min_next = 6'd0;
          if (hour_reg >= 5'd23) begin
            hour_next         = 5'd0;
            day_rollover_next = 1'b1;
          end else begin
            hour_next = hour_reg + 5'd1;
          end
        end else begin
          min_next = min_reg + 6'd1;
        end
      end else begin
        sec_next = sec_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hour_reg         <= 5'd0;
      min_reg          <= 6'd0;
      sec_reg          <= 6'd0;
      div_cnt_reg      <= '0;
      minute_tick_reg  <= 1'b0;
      day_rollover_reg <= 1'b0;
      load_error_reg   <= 1'b0;
    end else begin
      hour_reg         <= hour_next;
      min_reg          <= min_next;
      sec_reg          <= sec_next;
      div_cnt_reg      <= div_cnt_next;
      minute_tick_reg  <= minute_tick_next;
      day_rollover_reg <= day_rollover_next;
      load_error_reg   <= load_error_next;
    end
  end

  assign cur_hour     = hour_reg;
  assign cur_min      = min_reg;
  assign cur_sec      = sec_reg;
  assign minute_tick  = minute_tick_reg;
  assign day_rollover = day_rollover_reg;
  assign load_error   = load_error_reg;

`ifdef TOD_BCD_OUT_EN
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
    return {tens, ones};
  endfunction

  // Encoded from the next-state values so BCD changes on the same edge as binary.
  logic [7:0] hour_bcd_reg, min_bcd_reg, sec_bcd_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hour_bcd_reg <= 8'h00;
      min_bcd_reg  <= 8'h00;
      sec_bcd_reg  <= 8'h00;
    end else begin
      hour_bcd_reg <= to_bcd({1'b0, hour_next});
      min_bcd_reg  <= to_bcd(min_next);
      sec_bcd_reg  <= to_bcd(sec_next);
    end
  end

  assign hour_bcd = hour_bcd_reg;
  assign min_bcd  = min_bcd_reg;
  assign sec_bcd  = sec_bcd_reg;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench for time_of_day_counter: TICK_DIV=1 and TICK_DIV=4 instances checked
// against a seconds-of-day reference model. Define TOD_BCD_OUT_EN to also check BCD outputs.
module tb_time_of_day_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       hold = 1'b0;
  logic       load_new_time = 1'b0;
  logic [4:0] new_hour = 5'd0;
  logic [5:0] new_min = 6'd0;

  logic [4:0] cur_hour1, cur_hour4;
  logic [5:0] cur_min1, cur_min4, cur_sec1, cur_sec4;
  logic       minute_tick1, minute_tick4, day_rollover1, day_rollover4, load_error1, load_error4;
`ifdef TOD_BCD_OUT_EN
  logic [7:0] hour_bcd1, min_bcd1, sec_bcd1, hour_bcd4, min_bcd4, sec_bcd4;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  time_of_day_counter #(.TICK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .one_second(one_second), .hold(hold),
    .load_new_time(load_new_time), .new_hour(new_hour), .new_min(new_min),
    .cur_hour(cur_hour1), .cur_min(cur_min1), .cur_sec(cur_sec1),
    .minute_tick(minute_tick1), .day_rollover(day_rollover1), .load_error(load_error1)
`ifdef TOD_BCD_OUT_EN
    , .hour_bcd(hour_bcd1), .min_bcd(min_bcd1), .sec_bcd(sec_bcd1)
`endif
  );

  time_of_day_counter #(.TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .one_second(one_second), .hold(hold),
    .load_new_time(load_new_time), .new_hour(new_hour), .new_min(new_min),
    .cur_hour(cur_hour4), .cur_min(cur_min4), .cur_sec(cur_sec4),
    .minute_tick(minute_tick4), .day_rollover(day_rollover4), .load_error(load_error4)
`ifdef TOD_BCD_OUT_EN
    , .hour_bcd(hour_bcd4), .min_bcd(min_bcd4), .sec_bcd(sec_bcd4)
`endif
  );

  logic [19:0] obs1, obs4;
  assign obs1 = {cur_hour1, cur_min1, cur_sec1, minute_tick1, day_rollover1, load_error1};
  assign obs4 = {cur_hour4, cur_min4, cur_sec4, minute_tick4, day_rollover4, load_error4};

  // Reference model: time as seconds since midnight plus a pulse counter per instance.
  int div_m[2] = '{1, 4};
  int t_m[2];
  int p_m[2];
  bit mt_m[2], dr_m[2], le_m[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      t_m[k] = 0; p_m[k] = 0; mt_m[k] = 0; dr_m[k] = 0; le_m[k] = 0;
    end
  endfunction

  function automatic void model_cycle(bit one, bit hld, bit ld, int nh, int nm);
    for (int k = 0; k < 2; k++) begin
      mt_m[k] = 0; dr_m[k] = 0; le_m[k] = 0;
      if (ld) begin
        if (nh <= 23 && nm <= 59) begin
          t_m[k] = nh * 3600 + nm * 60;
          p_m[k] = 0;
        end else begin
          le_m[k] = 1;
        end
      end else if (!hld && one) begin
        p_m[k]++;
        if (p_m[k] == div_m[k]) begin
          p_m[k] = 0;
          t_m[k] = (t_m[k] + 1) % 86400;
          mt_m[k] = (t_m[k] % 60) == 0;
          dr_m[k] = (t_m[k] == 0);
        end
      end
    end
  endfunction

  function automatic logic [19:0] exp_vec(int k);
    int h, m, s;
    h = t_m[k] / 3600;
    m = (t_m[k] / 60) % 60;
    s = t_m[k] % 60;
    return {5'(h), 6'(m), 6'(s), mt_m[k], dr_m[k], le_m[k]};
  endfunction

`ifdef TOD_BCD_OUT_EN
  function automatic logic [23:0] exp_bcd(int k);
    int h, m, s;
    h = t_m[k] / 3600;
    m = (t_m[k] / 60) % 60;
    s = t_m[k] % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction
`endif

  // Drives one cycle of inputs, advances the model on the edge, returns 1 ns after the edge.
  task automatic cyc(input bit one, input bit hld, input bit ld, input int nh, input int nm);
    one_second = one; hold = hld; load_new_time = ld;
    new_hour = 5'(nh); new_min = 6'(nm);
    @(posedge clock);
    model_cycle(one, hld, ld, nh, nm);
    #1;
    one_second = 1'b0; hold = 1'b0; load_new_time = 1'b0;
  endtask

  task automatic test_reset();
    if (obs1 !== 20'd0 || obs4 !== 20'd0) begin
      errors++; $display("FAIL reset_initial got=%h/%h exp=0", obs1, obs4);
    end
    checks++;
    reset = 1'b0;
    cyc(0, 0, 1, 5, 17);
    for (int i = 0; i < 42; i++) cyc(1, 0, 0, 0, 0);
    if (obs1 !== exp_vec(0)) begin
      errors++; $display("FAIL reset_precount got=%h exp=%h", obs1, exp_vec(0));
    end
    checks++;
    #2 reset = 1'b1;
    #1;
    model_reset();
    if (obs1 !== 20'd0 || obs4 !== 20'd0) begin
      errors++; $display("FAIL reset_async got=%h/%h exp=0", obs1, obs4);
    end
    checks++;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    if (obs1 !== {5'd0, 6'd0, 6'd3, 3'b000} || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL reset_recount got=%h/%h exp=%h/%h", obs1, obs4,
                         {5'd0, 6'd0, 6'd3, 3'b000}, exp_vec(1));
    end
    checks++;
  endtask

  task automatic test_rollover();
    cyc(0, 0, 1, 23, 59);
    for (int i = 0; i < 59; i++) begin
      cyc(1, 0, 0, 0, 0);
      if (obs1 !== exp_vec(0) || obs4 !== exp_vec(1)) begin
        errors++; $display("FAIL rollover_count i=%0d got=%h/%h exp=%h/%h", i, obs1, obs4,
                           exp_vec(0), exp_vec(1));
      end
      checks++;
`ifdef TOD_BCD_OUT_EN
      if (i == 6) begin
        if ({hour_bcd1, min_bcd1, sec_bcd1} !== 24'h235907) begin
          errors++; $display("FAIL bcd_235907 got=%h exp=235907", {hour_bcd1, min_bcd1, sec_bcd1});
        end
        checks++;
      end
`endif
    end
    cyc(1, 0, 0, 0, 0);
    if (obs1 !== {17'd0, 3'b110} || obs1 !== exp_vec(0)) begin
      errors++; $display("FAIL rollover_wrap got=%h exp=%h", obs1, {17'd0, 3'b110});
    end
    checks++;
    cyc(0, 0, 0, 0, 0);
    if (obs1 !== 20'd0) begin
      errors++; $display("FAIL rollover_strobe_len got=%h exp=0", obs1);
    end
    checks++;
  endtask

  task automatic test_load_error();
    cyc(0, 0, 1, 12, 34);
    for (int i = 0; i < 56; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 24, 10);
    if (obs1 !== {5'd12, 6'd34, 6'd56, 3'b001} || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL load_err_hour got=%h/%h exp=%h/%h", obs1, obs4,
                         {5'd12, 6'd34, 6'd56, 3'b001}, exp_vec(1));
    end
    checks++;
    cyc(0, 0, 0, 0, 0);
    if (obs1 !== {5'd12, 6'd34, 6'd56, 3'b000}) begin
      errors++; $display("FAIL load_err_len got=%h exp=%h", obs1, {5'd12, 6'd34, 6'd56, 3'b000});
    end
    checks++;
    cyc(0, 0, 1, 12, 60);
    if (obs1 !== {5'd12, 6'd34, 6'd56, 3'b001} || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL load_err_min got=%h/%h exp=%h/%h", obs1, obs4,
                         {5'd12, 6'd34, 6'd56, 3'b001}, exp_vec(1));
    end
    checks++;
  endtask

  task automatic test_load_tick_collision();
    cyc(0, 0, 1, 7, 29);
    for (int i = 0; i < 59; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 7, 30);
    if (obs1 !== {5'd7, 6'd30, 6'd0, 3'b000} || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL load_tick_collide got=%h/%h exp=%h/%h", obs1, obs4,
                         {5'd7, 6'd30, 6'd0, 3'b000}, exp_vec(1));
    end
    checks++;
  endtask

  task automatic test_hold();
    cyc(0, 0, 1, 1, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, 0, 0);
      if (obs1 !== {5'd1, 6'd2, 6'd3, 3'b000} || obs4 !== exp_vec(1)) begin
        errors++; $display("FAIL hold_frozen i=%0d got=%h/%h exp=%h/%h", i, obs1, obs4,
                           {5'd1, 6'd2, 6'd3, 3'b000}, exp_vec(1));
      end
      checks++;
    end
    cyc(1, 0, 0, 0, 0);
    if (obs1 !== {5'd1, 6'd2, 6'd4, 3'b000}) begin
      errors++; $display("FAIL hold_release got=%h exp=%h", obs1, {5'd1, 6'd2, 6'd4, 3'b000});
    end
    checks++;
  endtask

  task automatic test_prescaler();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
    if (cur_sec4 !== 6'd1 || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL div4_seven got sec=%0d exp=1", cur_sec4);
    end
    checks++;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    if (cur_sec4 !== 6'd0 || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL div4_after_load got sec=%0d exp=0", cur_sec4);
    end
    checks++;
    cyc(1, 0, 0, 0, 0);
    if (cur_sec4 !== 6'd1 || obs4 !== exp_vec(1)) begin
      errors++; $display("FAIL div4_fourth got sec=%0d exp=1", cur_sec4);
    end
    checks++;
  endtask

  task automatic test_back_to_back_random();
    cyc(0, 0, 1, 23, 58);
    for (int i = 0; i < 3000; i++) begin
      bit one, hld, ld;
      int nh, nm;
      one = ($urandom_range(0, 9) < 8);
      hld = ($urandom_range(0, 19) == 0);
      ld  = ($urandom_range(0, 99) < 2);
      nh  = $urandom_range(0, 26);
      nm  = $urandom_range(0, 63);
      cyc(one, hld, ld, nh, nm);
      if (obs1 !== exp_vec(0) || obs4 !== exp_vec(1)) begin
        errors++; $display("FAIL random i=%0d got=%h/%h exp=%h/%h", i, obs1, obs4,
                           exp_vec(0), exp_vec(1));
      end
      checks++;
`ifdef TOD_BCD_OUT_EN
      if ({hour_bcd1, min_bcd1, sec_bcd1} !== exp_bcd(0) ||
          {hour_bcd4, min_bcd4, sec_bcd4} !== exp_bcd(1)) begin
        errors++; $display("FAIL random_bcd i=%0d got=%h/%h exp=%h/%h", i,
                           {hour_bcd1, min_bcd1, sec_bcd1}, {hour_bcd4, min_bcd4, sec_bcd4},
                           exp_bcd(0), exp_bcd(1));
      end
      checks++;
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_rollover();
    test_load_error();
    test_load_tick_collision();
    test_hold();
    test_prescaler();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Holds the running time of day as hours, minutes and seconds, advanced by the one-second strobe from the timing generator.
- Sits upstream of the alarm match comparator and supplies its cur_hour/cur_min inputs, replacing the demo time register in the top level.
- Loads a new time from the key buffer when the controller FSM asserts load_new_time.
- Emits one-cycle rollover strobes for the display and alarm logic.

Parameters:
- TICK_DIV, 1, number of one_second pulses per counted second. Must be ≥1. A value of 1 means every pulse advances seconds.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- one_second  input  1  tick strobe from the timing generator; each clock cycle high counts as one pulse
- hold  input  1  freeze counting; ticks arriving while high are discarded, not accumulated
- load_new_time  input  1  one-cycle load strobe from the controller FSM
- new_hour  input  5  hour to load, valid 0..23
- new_min  input  6  minute to load, valid 0..59
- cur_hour  output  5  current hour, 0..23
- cur_min  output  6  current minute, 0..59
- cur_sec  output  6  current second, 0..59
- minute_tick  output  1  one-cycle strobe when minutes advance by counting
- day_rollover  output  1  one-cycle strobe when the time wraps from 23:59:59 to 00:00:00
- load_error  output  1  one-cycle strobe when a load is rejected

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - cur_hour, cur_min and cur_sec = 0.
  - Prescaler count div_cnt = 0.
  - minute_tick, day_rollover and load_error = 0.
- All outputs are registered.
- Prescaler:
  - div_cnt has width max(1, clog2(TICK_DIV)).
  - On one_second=1 with hold=0 and no load: if div_cnt == TICK_DIV-1, div_cnt ← 0 and a second step occurs; otherwise div_cnt increments.
  - With TICK_DIV=1, every qualifying one_second pulse is a step.
- Second step (single cycle; the new time is visible on the next clock edge):
  - cur_sec < 59: cur_sec + 1.
  - cur_sec = 59: cur_sec ← 0 and minutes advance.
  - Minute advance: cur_min < 59 increments; cur_min = 59 → 0 and hours advance. minute_tick = 1 in the same cycle the new minute value appears.
  - Hour advance: cur_hour < 23 increments; cur_hour = 23 → 0. day_rollover = 1 in the same cycle 00:00:00 appears.
- Load (load_new_time = 1):
  - Valid when new_hour ≤ 23 and new_min ≤ 59. Then cur_hour ← new_hour, cur_min ← new_min, cur_sec ← 0 and div_cnt ← 0, visible the next cycle.
  - A load produces no minute_tick or day_rollover.
  - Invalid values: the time is unchanged, div_cnt is unchanged, any tick in the same cycle is discarded, and load_error pulses for 1 cycle.
- Priority when events coincide in one cycle: load (valid or invalid) > hold > tick. A tick coinciding with any load is dropped.
- hold = 1: time and div_cnt are frozen; loads are still accepted.
- Strobes are high for exactly one cycle per event and never stretch. Back-to-back ticks (one_second high continuously) with TICK_DIV=1 advance one second per clock.
- Out-of-range internal states are unreachable. If one is forced, the next step wraps the field to 0 as if it were at its maximum.

Optional Feature:
- Macro: TOD_BCD_OUT_EN.
- Defined: adds outputs hour_bcd[7:0], min_bcd[7:0] and sec_bcd[7:0], each two BCD digits with the tens digit in [7:4].
  - Each is registered and updated in the same cycle as its binary counterpart, so it never lags.
  - Reset value is 8'h00. Example: 23:59:07 → 8'h23, 8'h59, 8'h07.
- Undefined: these ports do not exist and no BCD logic is synthesized. Binary behaviour is identical in both builds.

Test Plan:
- Reset mid-count at 05:17:42 → all outputs 0 immediately. After release with TICK_DIV=1, 3 ticks → 00:00:03.
- Load 23:59, then 59 ticks → 23:59:59 with no strobe. 1 more tick → 00:00:00, with day_rollover=1 and minute_tick=1 for exactly that one cycle.
- Load new_hour=24, new_min=10 while at 12:34:56 → load_error pulses 1 cycle and the time stays 12:34:56. Load new_min=60 → same result.
- Load 07:30 in the same cycle as a tick at 07:29:59 → 07:30:00 next cycle, with no minute_tick and no load_error.
- hold=1 for 10 ticks at 01:02:03 → still 01:02:03. Release hold and apply 1 tick → 01:02:04.
- TICK_DIV=4: 7 pulses → cur_sec=1. A load then resets the prescaler, so 3 more pulses → cur_sec=0 and the 4th → cur_sec=1. With TOD_BCD_OUT_EN, at 23:59:07 → hour_bcd=8'h23, min_bcd=8'h59, sec_bcd=8'h07.
